// File: rtl/risac_lsu_avm.sv
// risac_lsu_avm
// Load/store Avalon-MM master for the risac core. Accepts one RV32I load or
// store at a time and turns it into a single 32-bit Avalon-MM transfer.
// Stores are placed on the correct byte lanes with a matching byteenable.
// Load data is shifted down and then sign- or zero-extended. Misaligned or
// illegal accesses get an error response and cause no bus traffic.
//
// Ports
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   req_*               core request (valid/ready), we, funct3, addr, wdata
//   rsp_*               one-cycle response pulse with rdata and err
//   avm_*               Avalon-MM master (address, byteenable, read, write,
//                       writedata, waitrequest, readdata, readdatavalid)
//   dbg_state           current FSM state (0 IDLE, 1 BUS, 2 RDWAIT)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. rsp_valid is a
// single-cycle pulse, and the block ignores its consumer (no rsp_ready).
// On the bus, a command transfers on the first edge where avm_read or
// avm_write is high and avm_waitrequest is low.

module risac_lsu_avm #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic [3:0]            avm_byteenable,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [31:0]           avm_writedata,
    input  logic                  avm_waitrequest,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS    = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    // The funct3 and low address bits are kept for read extraction.
    logic [2:0] fn3_q, fn3_d;
    logic [1:0] lane_q, lane_d;

    // Next values of the registered outputs.
    logic                  read_d, write_d;
    logic [ADDR_WIDTH-1:0] address_d;
    logic [3:0]            be_d;
    logic [31:0]           wdata_d;
    logic                  rsp_valid_d, rsp_err_d;
    logic [31:0]           rsp_rdata_d;

    logic                  req_legal;
    logic [3:0]            store_be;
    logic [31:0]           store_data;
    logic [31:0]           rd_shift;
    logic [31:0]           load_data;

    assign req_ready = (state == IDLE);
    assign dbg_state = state;

    // Legality check. Stores 011 are rejected as well, because RV32I
    // defines no store with that encoding.
    always_comb begin
        req_legal = 1'b1;
        if (req_we) begin
            if (req_funct3[2] || (req_funct3[1:0] == 2'b11)) req_legal = 1'b0;
        end else begin
            if ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)) req_legal = 1'b0;
        end
        if ((req_funct3[1:0] == 2'b01) && req_addr[0])          req_legal = 1'b0;
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) req_legal = 1'b0;
    end

    // Lane placement. Data is replicated across the lanes, so the
    // byteenable alone selects which bytes the slave writes.
    always_comb begin
        store_be   = 4'b1111;
        store_data = req_wdata;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    store_be   = 4'b0001 << req_addr[1:0];
                    store_data = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    store_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                    store_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    store_be   = 4'b1111;
                    store_data = req_wdata;
                end
            endcase
        end
    end

    // Read extraction: shift the addressed byte or halfword down to bit 0,
    // then extend it.
    assign rd_shift = avm_readdata >> {lane_q, 3'b000};

    always_comb begin
        case (fn3_q)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_data = {24'h000000, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_data = {16'h0000, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            fn3_q          <= 3'b000;
            lane_q         <= 2'b00;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= 4'b0000;
            avm_writedata  <= 32'h0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= 32'h0;
        end else begin
            state          <= state_nxt;
            fn3_q          <= fn3_d;
            lane_q         <= lane_d;
            avm_read       <= read_d;
            avm_write      <= write_d;
            avm_address    <= address_d;
            avm_byteenable <= be_d;
            avm_writedata  <= wdata_d;
            rsp_valid      <= rsp_valid_d;
            rsp_err        <= rsp_err_d;
            rsp_rdata      <= rsp_rdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid && req_legal) state_nxt = BUS;
            BUS:     if (!avm_waitrequest) state_nxt = avm_write ? IDLE : RDWAIT;
            RDWAIT:  if (avm_readdatavalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. This computes the next value of every registered
    // output. The bus fields hold their value unless a new command loads
    // them. The response fields are zero except in the cycle that produces
    // a response.
    always_comb begin
        fn3_d       = fn3_q;
        lane_d      = lane_q;
        read_d      = avm_read;
        write_d     = avm_write;
        address_d   = avm_address;
        be_d        = avm_byteenable;
        wdata_d     = avm_writedata;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    fn3_d  = req_funct3;
                    lane_d = req_addr[1:0];
                    if (req_legal) begin
                        read_d    = ~req_we;
                        write_d   = req_we;
                        address_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        be_d      = store_be;
                        wdata_d   = store_data;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            BUS: begin
                if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (avm_write) rsp_valid_d = 1'b1;
                end
            end
            RDWAIT: begin
                if (avm_readdatavalid) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data;
                end
            end
            default: begin
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_risac_lsu_avm.sv
// Testbench for risac_lsu_avm. A behavioural Avalon slave with read
// latency 1 and programmable stalls drives the bus side. Expected results
// come from a byte-level model of memory and of the RV32I load/store rules.
module tb_risac_lsu_avm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [16:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [16:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [1:0]  dbg_state;

    risac_lsu_avm #(.ADDR_WIDTH(17)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_funct3        (req_funct3),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .avm_address       (avm_address),
        .avm_byteenable    (avm_byteenable),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .dbg_state         (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Slave memory (what the bus sees) and reference memory (model).
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    // Slave state, shared with the main sequence.
    int          stall_left = 0;
    int          acc_cnt    = 0;
    int          cmd_cycles = 0;
    bit          was_stall  = 0;
    bit          just_acc   = 0;
    bit          rd_pend    = 0;
    logic [31:0] rd_data;
    logic [16:0] last_addr, hold_addr;
    logic [3:0]  last_be, hold_be;
    logic [31:0] last_wdata, hold_wdata;
    logic        last_we, hold_we;

    // Avalon slave: read latency 1, waitrequest for stall_left cycles per command.
    always @(negedge clk) begin
        avm_readdatavalid = rd_pend;
        avm_readdata      = rd_pend ? rd_data : $urandom();
        rd_pend           = 1'b0;
        if (just_acc) chk("cmd_drop", {30'd0, avm_read, avm_write}, 32'd0);
        just_acc = 1'b0;
        if (avm_read || avm_write) begin
            cmd_cycles++;
            chk("cmd_onehot", {31'd0, avm_read & avm_write}, 32'd0);
            if (was_stall) begin
                chk("stall_addr",  {15'd0, avm_address}, {15'd0, hold_addr});
                chk("stall_be",    {28'd0, avm_byteenable}, {28'd0, hold_be});
                chk("stall_wdata", avm_writedata, hold_wdata);
                chk("stall_kind",  {31'd0, avm_write}, {31'd0, hold_we});
            end
            hold_addr  = avm_address;
            hold_be    = avm_byteenable;
            hold_wdata = avm_writedata;
            hold_we    = avm_write;
            if (stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
                was_stall = 1'b1;
            end else begin
                avm_waitrequest = 1'b0;
                was_stall  = 1'b0;
                just_acc   = 1'b1;
                acc_cnt++;
                last_addr  = avm_address;
                last_be    = avm_byteenable;
                last_wdata = avm_writedata;
                last_we    = avm_write;
                if (avm_write) begin
                    for (int b = 0; b < 4; b++)
                        if (avm_byteenable[b]) mem[avm_address[7:2]][8*b +: 8] = avm_writedata[8*b +: 8];
                end else begin
                    rd_pend = 1'b1;
                    rd_data = mem[avm_address[7:2]];
                end
            end
        end else begin
            avm_waitrequest = 1'($urandom_range(0, 1));
            was_stall = 1'b0;
        end
    end

    // Reference model of one access, from the ISA rules.
    function automatic int op_size(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit op_legal(input logic we, input logic [2:0] f3, input int addr);
        bit ok;
        if (we) ok = (f3 <= 3'd2);
        else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return ok && ((addr % op_size(f3)) == 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input int off,
                                               input int size, input bit sgn);
        longint v;
        v = longint'(word) >> (8 * off);
        if (size < 4) begin
            v = v % (longint'(1) << (8 * size));
            if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
        end
        return v[31:0];
    endfunction

    // One request: wait for ready, send, wait for the response, then check.
    task automatic run_txn(input logic we, input logic [2:0] f3, input int addr,
                           input logic [31:0] wd, input int stalls, output logic [31:0] rdata);
        bit          legal;
        int          size, off, idx, guard, cnt, acc0, cmd0, exp_lat;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;
        legal  = op_legal(we, f3, addr);
        size   = op_size(f3);
        off    = addr % 4;
        idx    = (addr / 4) % 64;
        exp_be = 4'hF;
        exp_wd = wd;
        exp_rd = 32'h0;
        if (legal && we) begin
            exp_be = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % size) +: 8];
            for (int i = 0; i < 4; i++) if (exp_be[i]) ref_mem[idx][8*i +: 8] = exp_wd[8*i +: 8];
        end
        if (legal && !we) exp_rd = model_load(ref_mem[idx], off, size, !f3[2]);
        exp_lat = !legal ? 1 : (we ? 2 + stalls : 3 + stalls);

        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        acc0       = acc_cnt;
        cmd0       = cmd_cycles;
        stall_left = legal ? stalls : 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = 17'(addr);
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_wdata  = $urandom();
        cnt = 1;
        while (!rsp_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        rdata = rsp_rdata;
        chk("rsp_valid",   {31'd0, rsp_valid}, 32'd1);
        chk("latency",     cnt, exp_lat);
        chk("rsp_err",     {31'd0, rsp_err}, {31'd0, !legal});
        chk("rsp_rdata",   rsp_rdata, exp_rd);
        chk("accepts",     acc_cnt - acc0, legal ? 1 : 0);
        chk("cmd_cycles",  cmd_cycles - cmd0, legal ? stalls + 1 : 0);
        if (legal) begin
            chk("bus_addr", {15'd0, last_addr}, 32'(addr - off));
            chk("bus_be",   {28'd0, last_be}, {28'd0, exp_be});
            chk("bus_kind", {31'd0, last_we}, {31'd0, we});
            if (we) chk("bus_wdata", last_wdata, exp_wd);
        end
    endtask

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Main sequence
    initial begin
        logic [31:0] rd;
        logic [31:0] rd2;
        int          guard;
        reset_n           = 1'b0;
        req_valid         = 1'b0;
        req_we            = 1'b0;
        req_funct3        = 3'd0;
        req_addr          = '0;
        req_wdata         = '0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        mem[8]     = 32'h12348000;
        ref_mem[8] = 32'h12348000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read",   {31'd0, avm_read}, 32'd0);
        chk("rst_write",  {31'd0, avm_write}, 32'd0);
        chk("rst_addr",   {15'd0, avm_address}, 32'd0);
        chk("rst_be",     {28'd0, avm_byteenable}, 32'd0);
        chk("rst_wdata",  avm_writedata, 32'd0);
        chk("rst_rsp",    {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("rst_rdata",  rsp_rdata, 32'd0);
        chk("rst_state",  {30'd0, dbg_state}, 32'd0);
        chk("rst_ready",  {31'd0, req_ready}, 32'd1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // SW 0x10, no wait states
        run_txn(1'b1, 3'b010, 'h10, 32'hDEADBEEF, 0, rd);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        // SB 0x13, three stall cycles
        run_txn(1'b1, 3'b000, 'h13, 32'h000000A5, 3, rd);
        chk("sb_be",    {28'd0, last_be}, 32'h8);
        chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
        run_txn(1'b0, 3'b010, 'h10, 32'h0, 1, rd);
        chk("sb_readback", rd, 32'hA5ADBEEF);

        // Extension cases against the fixed word 0x12348000
        run_txn(1'b0, 3'b000, 'h21, 32'h0, 0, rd);
        chk("lb_const", rd, 32'hFFFFFF80);
        run_txn(1'b0, 3'b100, 'h21, 32'h0, 0, rd);
        chk("lbu_const", rd, 32'h00000080);
        run_txn(1'b0, 3'b101, 'h22, 32'h0, 0, rd);
        chk("lhu_const", rd, 32'h00001234);
        run_txn(1'b0, 3'b001, 'h20, 32'h0, 2, rd);
        chk("lh_const", rd, 32'hFFFF8000);

        // Misaligned LW and illegal encodings
        run_txn(1'b0, 3'b010, 'h06, 32'h0, 0, rd);
        chk("lw_mis_rdata", rd, 32'h0);
        run_txn(1'b1, 3'b001, 'h05, 32'h1234, 0, rd);
        run_txn(1'b0, 3'b111, 'h08, 32'h0, 0, rd);
        run_txn(1'b1, 3'b100, 'h08, 32'h55, 0, rd);

        // Back-to-back LW 0x0 then LW 0x4
        run_txn(1'b0, 3'b010, 'h00, 32'h0, 0, rd);
        chk("b2b_ready", {31'd0, req_ready}, 32'd1);
        run_txn(1'b0, 3'b010, 'h04, 32'h0, 0, rd2);
        chk("b2b_first",  rd,  ref_mem[0]);
        chk("b2b_second", rd2, ref_mem[1]);

        // Reset while a read is stalled
        stall_left = 20;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 17'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("stalled_read", {31'd0, avm_read}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_read", {31'd0, avm_read}, 32'd0);
        chk("rst_async_rsp",  {31'd0, rsp_valid}, 32'd0);
        stall_left = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_hold_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        reset_n = 1'b1;
        chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);
        guard = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || avm_read) guard++;
        end
        chk("rst_no_rsp", guard, 0);
        run_txn(1'b0, 3'b010, 'h40, 32'h0, 1, rd);

        // Randomized accesses
        for (int n = 0; n < 80; n++) begin
            logic       we;
            logic [2:0] f3;
            we = 1'($urandom_range(0, 1));
            if (we) f3 = ($urandom_range(0, 7) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 2));
            else    f3 = 3'($urandom_range(0, 7));
            run_txn(we, f3, $urandom_range(0, 255), $urandom(), $urandom_range(0, 3), rd);
        end

        // Final sweep: every word read back through the bus
        for (int i = 0; i < 64; i += 9) run_txn(1'b0, 3'b010, i * 4, 32'h0, 0, rd);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
